// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - core request bus and SRAM port bundle for mem_responder
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  mem_rden;
  logic                  mem_wren;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic [2:0]            mem_funct3;
  logic                  done;
  logic [31:0]           rdata;
  logic                  err;
  logic                  sram_ce;
  logic                  sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [31:0]           sram_wdata;
  logic [31:0]           sram_rdata;

  // master = core plus SRAM macro side, slave = the responder
  modport master (
    output mem_rden, mem_wren, mem_addr, mem_wdata, mem_funct3, sram_rdata,
    input  done, rdata, err, sram_ce, sram_we, sram_addr, sram_wdata
  );

  modport slave (
    input  mem_rden, mem_wren, mem_addr, mem_wdata, mem_funct3, sram_rdata,
    output done, rdata, err, sram_ce, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - byte-addressed load/store responder over a word-wide SRAM without byte enables
module mem_responder #(
  parameter int ADDR_WIDTH   = 14,
  parameter int READ_LATENCY = 1
) (
  input logic            clk,
  input logic            rst_n,
  mem_responder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD_WAIT, RMW_WAIT, WR, RESP} state_t;
  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            off_q, off_d;
  logic [15:0]           st_q, st_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  sram_ce_q, sram_ce_d;
  logic                  sram_we_q, sram_we_d;
  logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic [31:0]           sram_wdata_q, sram_wdata_d;

  logic                  req_err;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic [31:0]           load_ext;
  logic [31:0]           merged;
  logic                  unused_addr_bits;

  // byte addresses wrap: the bits above the SRAM word address are ignored
  assign unused_addr_bits = ^bus.mem_addr[31:ADDR_WIDTH+2];

  always_comb begin
    case (bus.mem_funct3)
      3'd0:    req_err = 1'b0;
      3'd1:    req_err = bus.mem_addr[0];
      3'd2:    req_err = |bus.mem_addr[1:0];
      3'd4:    req_err = bus.mem_wren;
      3'd5:    req_err = bus.mem_wren | bus.mem_addr[0];
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    case (off_q)
      2'd0:    lane_b = bus.sram_rdata[7:0];
      2'd1:    lane_b = bus.sram_rdata[15:8];
      2'd2:    lane_b = bus.sram_rdata[23:16];
      default: lane_b = bus.sram_rdata[31:24];
    endcase
    lane_h = off_q[1] ? bus.sram_rdata[31:16] : bus.sram_rdata[15:0];
    case (f3_q)
      3'd0:    load_ext = {{24{lane_b[7]}}, lane_b};
      3'd1:    load_ext = {{16{lane_h[15]}}, lane_h};
      3'd4:    load_ext = {24'h0, lane_b};
      3'd5:    load_ext = {16'h0, lane_h};
      default: load_ext = bus.sram_rdata;
    endcase
  end

  // sub-word store: splice the latched byte/half into the word just read back
  always_comb begin
    merged = bus.sram_rdata;
    if (f3_q[0]) begin
      if (off_q[1]) merged[31:16] = st_q;
      else          merged[15:0]  = st_q;
    end else begin
      case (off_q)
        2'd0:    merged[7:0]   = st_q[7:0];
        2'd1:    merged[15:8]  = st_q[7:0];
        2'd2:    merged[23:16] = st_q[7:0];
        default: merged[31:24] = st_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    f3_d         = f3_q;
    off_d        = off_q;
    st_d         = st_q;
    rdata_d      = rdata_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    sram_ce_d    = 1'b0;
    sram_we_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_rden || bus.mem_wren) begin
          f3_d  = bus.mem_funct3;
          off_d = bus.mem_addr[1:0];
          st_d  = bus.mem_wdata[15:0];
          cnt_d = 3'd0;
          if (req_err) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            sram_ce_d   = 1'b1;
            sram_addr_d = bus.mem_addr[ADDR_WIDTH+1:2];
            if (bus.mem_wren && bus.mem_funct3 == 3'd2) begin
              sram_we_d    = 1'b1;
              sram_wdata_d = bus.mem_wdata;
              state_d      = WR;
            end else if (bus.mem_wren) begin
              state_d = RMW_WAIT;
            end else begin
              state_d = RD_WAIT;
            end
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == LAT) begin
          rdata_d = load_ext;
          done_d  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RMW_WAIT: begin
        if (cnt_q == LAT) begin
          sram_ce_d    = 1'b1;
          sram_we_d    = 1'b1;
          sram_wdata_d = merged;
          state_d      = WR;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WR: begin
        done_d  = 1'b1;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      f3_q         <= 3'd0;
      off_q        <= 2'd0;
      st_q         <= 16'h0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= 32'h0;
      sram_ce_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      st_q         <= st_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      sram_ce_q    <= sram_ce_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.rdata      = rdata_q;
  assign bus.sram_ce    = sram_ce_q;
  assign bus.sram_we    = sram_we_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_wdata = sram_wdata_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed and randomized checks of mem_responder at read latencies 1 and 3
module tb_mem_responder;
  localparam int AW  = 8;
  localparam int NW  = 1 << AW;
  localparam int NB  = NW * 4;
  localparam int RL1 = 1;
  localparam int RL3 = 3;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic load_mem = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_WIDTH(AW)) b1 ();
  mem_responder_if #(.ADDR_WIDTH(AW)) b3 ();

  mem_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(RL1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  mem_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(RL3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  logic [7:0]  ref_b [NB];
  logic [31:0] mem1 [NW];
  logic [31:0] mem3 [NW];
  logic [31:0] p1;
  logic [31:0] p3 [3];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_rdata = 32'h0;

  function automatic logic [31:0] ref_word(input int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  // SRAM macros: reads return junk except exactly READ_LATENCY cycles after the strobe
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < NW; i++) mem1[i] <= ref_word(i);
    end else if (b1.sram_ce && b1.sram_we) begin
      mem1[b1.sram_addr] <= b1.sram_wdata;
    end
    p1 <= (b1.sram_ce && !b1.sram_we) ? mem1[b1.sram_addr] : $urandom;
  end
  assign b1.sram_rdata = p1;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < NW; i++) mem3[i] <= ref_word(i);
    end else if (b3.sram_ce && b3.sram_we) begin
      mem3[b3.sram_addr] <= b3.sram_wdata;
    end
    p3[0] <= (b3.sram_ce && !b3.sram_we) ? mem3[b3.sram_addr] : $urandom;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign b3.sram_rdata = p3[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_buses();
    b1.mem_rden = 1'b0; b1.mem_wren = 1'b0; b1.mem_addr = 32'h0; b1.mem_wdata = 32'h0; b1.mem_funct3 = 3'd0;
    b3.mem_rden = 1'b0; b3.mem_wren = 1'b0; b3.mem_addr = 32'h0; b3.mem_wdata = 32'h0; b3.mem_funct3 = 3'd0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ce1"},    32'(b1.sram_ce),    32'd0);
    chk({tag, "_we1"},    32'(b1.sram_we),    32'd0);
    chk({tag, "_done1"},  32'(b1.done),       32'd0);
    chk({tag, "_err1"},   32'(b1.err),        32'd0);
    chk({tag, "_rdata1"}, b1.rdata,           32'd0);
    chk({tag, "_addr1"},  32'(b1.sram_addr),  32'd0);
    chk({tag, "_wdata1"}, b1.sram_wdata,      32'd0);
    chk({tag, "_ce3"},    32'(b3.sram_ce),    32'd0);
    chk({tag, "_we3"},    32'(b3.sram_we),    32'd0);
    chk({tag, "_done3"},  32'(b3.done),       32'd0);
    chk({tag, "_rdata3"}, b3.rdata,           32'd0);
    chk({tag, "_addr3"},  32'(b3.sram_addr),  32'd0);
  endtask

  // One request on both responders; the reference treats memory as a flat byte array.
  task automatic run_txn(input string tag, input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3,
                         output logic [31:0] got_rdata, output logic [31:0] got_wword);
    int size, a, exp_nr, exp_nw, xl1, xl3;
    int lat1, lat3, nr1, nw1, nr3, nw3;
    bit e;
    logic [31:0] v, exp_ww, rd1, rd3, ww1, ww3;
    logic er1, er3, post1, post3;

    a = int'(addr[AW+1:0]);
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    e = 1'b0;
    if (size == 0) e = 1'b1;
    else if (a % size != 0) e = 1'b1;
    if (wr && f3[2]) e = 1'b1;
    exp_ww = 32'h0; exp_nr = 0; exp_nw = 0;
    if (e) begin
      xl1 = 1; xl3 = 1;
    end else if (!wr) begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(ref_b[a+i]) << (8*i));
      if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
      if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
      exp_rdata = v;
      exp_nr = 1; xl1 = 2 + RL1; xl3 = 2 + RL3;
    end else begin
      for (int i = 0; i < size; i++) ref_b[a+i] = wdata[8*i +: 8];
      exp_ww = ref_word(a / 4);
      exp_nw = 1;
      if (size == 4) begin xl1 = 2; xl3 = 2; end
      else begin exp_nr = 1; xl1 = 3 + RL1; xl3 = 3 + RL3; end
    end

    b1.mem_rden = rd; b1.mem_wren = wr; b1.mem_addr = addr; b1.mem_wdata = wdata; b1.mem_funct3 = f3;
    b3.mem_rden = rd; b3.mem_wren = wr; b3.mem_addr = addr; b3.mem_wdata = wdata; b3.mem_funct3 = f3;
    lat1 = 0; lat3 = 0; nr1 = 0; nw1 = 0; nr3 = 0; nw3 = 0;
    er1 = 1'b0; er3 = 1'b0; rd1 = 32'h0; rd3 = 32'h0; ww1 = 32'h0; ww3 = 32'h0;
    post1 = 1'b0; post3 = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (lat1 == 0) begin
        if (b1.sram_ce && !b1.sram_we) nr1++;
        if (b1.sram_ce && b1.sram_we) begin nw1++; ww1 = b1.sram_wdata; end
        if (b1.done) begin
          lat1 = k; er1 = b1.err; rd1 = b1.rdata; b1.mem_rden = 1'b0; b1.mem_wren = 1'b0;
        end else begin
          b1.mem_addr = $urandom; b1.mem_wdata = $urandom; b1.mem_funct3 = 3'($urandom);
        end
      end else if (k == lat1 + 1) begin
        post1 = b1.done | b1.sram_ce;
      end
      if (lat3 == 0) begin
        if (b3.sram_ce && !b3.sram_we) nr3++;
        if (b3.sram_ce && b3.sram_we) begin nw3++; ww3 = b3.sram_wdata; end
        if (b3.done) begin
          lat3 = k; er3 = b3.err; rd3 = b3.rdata; b3.mem_rden = 1'b0; b3.mem_wren = 1'b0;
        end else begin
          b3.mem_addr = $urandom; b3.mem_wdata = $urandom; b3.mem_funct3 = 3'($urandom);
        end
      end else if (k == lat3 + 1) begin
        post3 = b3.done | b3.sram_ce;
      end
      if (lat1 != 0 && lat3 != 0 && k > lat1 && k > lat3) break;
    end

    chk({tag, "_lat1"},   32'(lat1), 32'(xl1));
    chk({tag, "_lat3"},   32'(lat3), 32'(xl3));
    chk({tag, "_err1"},   32'(er1),  32'(e));
    chk({tag, "_err3"},   32'(er3),  32'(e));
    chk({tag, "_rdata1"}, rd1,       exp_rdata);
    chk({tag, "_rdata3"}, rd3,       exp_rdata);
    chk({tag, "_nrd1"},   32'(nr1),  32'(exp_nr));
    chk({tag, "_nwr1"},   32'(nw1),  32'(exp_nw));
    chk({tag, "_nrd3"},   32'(nr3),  32'(exp_nr));
    chk({tag, "_nwr3"},   32'(nw3),  32'(exp_nw));
    chk({tag, "_after1"}, 32'(post1), 32'd0);
    chk({tag, "_after3"}, 32'(post3), 32'd0);
    if (wr && !e) begin
      chk({tag, "_wword1"}, ww1, exp_ww);
      chk({tag, "_wword3"}, ww3, exp_ww);
    end
    got_rdata = rd1;
    got_wword = ww1;
  endtask

  initial begin
    logic [31:0] r, w, ra, rw;
    logic [2:0]  rf;
    int          sel, quiet;

    idle_buses();
    for (int i = 0; i < NB; i++) ref_b[i] = 8'($urandom);
    ref_b[16] = 8'hF0; ref_b[17] = 8'h00; ref_b[18] = 8'h00; ref_b[19] = 8'h80;
    load_mem = 1'b1;
    @(posedge clk);
    #1 load_mem = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_release");

    run_txn("lw10",  1'b1, 1'b0, 32'h10, 32'h0, 3'd2, r, w);
    chk("lw10_val", r, 32'h8000_00F0);
    run_txn("sw10",  1'b0, 1'b1, 32'h10, 32'h80FF_7F01, 3'd2, r, w);
    run_txn("lb13",  1'b1, 1'b0, 32'h13, 32'h0, 3'd0, r, w);
    chk("lb13_val", r, 32'hFFFF_FF80);
    run_txn("lbu13", 1'b1, 1'b0, 32'h13, 32'h0, 3'd4, r, w);
    chk("lbu13_val", r, 32'h0000_0080);
    run_txn("lh12",  1'b1, 1'b0, 32'h12, 32'h0, 3'd1, r, w);
    chk("lh12_val", r, 32'hFFFF_80FF);
    run_txn("sw20",  1'b0, 1'b1, 32'h20, 32'h1122_3344, 3'd2, r, w);
    run_txn("sb21",  1'b0, 1'b1, 32'h21, 32'h5555_55AB, 3'd0, r, w);
    chk("sb21_merge", w, 32'h1122_AB44);
    run_txn("lw20",  1'b1, 1'b0, 32'h20, 32'h0, 3'd2, r, w);
    chk("lw20_val", r, 32'h1122_AB44);
    run_txn("lw06",  1'b1, 1'b0, 32'h06, 32'h0, 3'd2, r, w);
    chk("lw06_hold", r, 32'h1122_AB44);
    run_txn("sh03",  1'b0, 1'b1, 32'h03, 32'hFFFF, 3'd1, r, w);
    chk("sh03_hold", r, 32'h1122_AB44);
    run_txn("sbu40", 1'b0, 1'b1, 32'h40, 32'h12, 3'd4, r, w);
    run_txn("ld_f3", 1'b1, 1'b0, 32'h40, 32'h0, 3'd3, r, w);
    run_txn("st_f7", 1'b0, 1'b1, 32'h40, 32'h0, 3'd7, r, w);
    run_txn("both",  1'b1, 1'b1, 32'h30, 32'hDEAD_BEEF, 3'd2, r, w);
    run_txn("lw30",  1'b1, 1'b0, 32'h30, 32'h0, 3'd2, r, w);
    chk("lw30_val", r, 32'hDEAD_BEEF);
    run_txn("wrap_lw", 1'b1, 1'b0, 32'hABCD_0410, 32'h0, 3'd2, r, w);
    chk("wrap_lw_val", r, 32'h80FF_7F01);
    run_txn("wrap_sh", 1'b0, 1'b1, 32'hFFFF_FC22, 32'h0000_BEEF, 3'd1, r, w);
    chk("wrap_sh_merge", w, 32'hBEEF_AB44);

    for (int t = 0; t < 60; t++) begin
      rf  = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rw  = $urandom;
      sel = $urandom_range(0, 2);
      if ($urandom_range(0, 3) != 0) begin
        if (rf[1:0] == 2'd2) ra[1:0] = 2'd0;
        if (rf[1:0] == 2'd1) ra[0] = 1'b0;
      end
      run_txn($sformatf("rnd%0d", t), sel != 1, sel != 0, ra, rw, rf, r, w);
    end

    // abandon a read-modify-write mid-flight with an asynchronous reset
    b1.mem_rden = 1'b0; b1.mem_wren = 1'b1; b1.mem_addr = 32'h24; b1.mem_wdata = 32'h77; b1.mem_funct3 = 3'd0;
    b3.mem_rden = 1'b0; b3.mem_wren = 1'b1; b3.mem_addr = 32'h24; b3.mem_wdata = 32'h77; b3.mem_funct3 = 3'd0;
    @(posedge clk);
    @(negedge clk);
    chk("rmw_rd_strobe1", 32'(b1.sram_ce), 32'd1);
    chk("rmw_rd_strobe3", 32'(b3.sram_ce), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    idle_buses();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_rdata = 32'h0;
    quiet = 0;
    repeat (8) begin
      @(negedge clk);
      if (b1.done || b3.done || b1.sram_ce || b3.sram_ce) quiet++;
    end
    chk("post_rst_quiet", 32'(quiet), 32'd0);
    run_txn("post_rst_lw", 1'b1, 1'b0, 32'h24, 32'h0, 3'd2, r, w);

    @(negedge clk);
    for (int i = 0; i < NW; i++) begin
      chk($sformatf("mem1_w%0d", i), mem1[i], ref_word(i));
      chk($sformatf("mem3_w%0d", i), mem3[i], ref_word(i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
